// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the accumulating processing element (pe_mac) and
// its pipelined multiplier (pe_mul):
//   - accumulator FSM state encoding
//   - bit positions of the first/last flags carried alongside the product
//   - helpers that derive the saturation limits from the accumulator width
//     (used only when the design is built with PE_SAT_EN defined)
// ---------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } pe_state_e;

    // Flag vector travelling with the stage-1 product
    localparam int FLAG_FIRST = 0;
    localparam int FLAG_LAST  = 1;
    localparam int FLAG_W     = 2;

    // Saturation helpers return a 64-bit pattern; callers truncate to ACCW,
    // so accumulators up to 64 bits are covered.
    // Upper limit: 2^(w-1)-1 when signed, 2^w-1 when unsigned.
    function automatic logic [63:0] sat_max(input int accw, input bit sgn);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < (sgn ? accw - 1 : accw)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Lower limit: -2^(w-1) when signed, 0 when unsigned.
    function automatic logic [63:0] sat_min(input int accw, input bit sgn);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (sgn && (i == accw - 1)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pe_mul.sv
// ---------------------------------------------------------------------------
// pe_mul
// Registered DW x DW multiplier forming pipeline stage 1 of pe_mac.
// On a qualified pair (go_i) it captures the 2*DW-bit product, signed or
// unsigned according to SIGNED, together with the first/last flags.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   go_i       pair qualified this cycle
//   a_i, b_i   operands (DW bits)
//   first_i    pair starts a dot product
//   last_i     pair ends a dot product
//   p_vld_o    product register holds a fresh product
//   p_o        product (2*DW bits)
//   flags_o    first/last flags, indexed by FLAG_FIRST / FLAG_LAST
// ---------------------------------------------------------------------------
module pe_mul
    import pe_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_i,
    input  logic [DW-1:0]     a_i,
    input  logic [DW-1:0]     b_i,
    input  logic              first_i,
    input  logic              last_i,
    output logic              p_vld_o,
    output logic [2*DW-1:0]   p_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic [2*DW-1:0]   a_ext;
    logic [2*DW-1:0]   b_ext;
    logic [2*DW-1:0]   prod_d;
    logic              p_vld_q;
    logic [2*DW-1:0]   p_q;
    logic [FLAG_W-1:0] flags_q;

    // The low 2*DW bits of a product of sign-extended operands equal the
    // two's-complement product, so one multiplier serves both modes.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[DW-1:0] = a_i;
        b_ext[DW-1:0] = b_i;
        for (int i = DW; i < 2*DW; i++) begin
            a_ext[i] = (SIGNED != 0) & a_i[DW-1];
            b_ext[i] = (SIGNED != 0) & b_i[DW-1];
        end
        prod_d = a_ext * b_ext;
    end

    // Product and flags are only meaningful while p_vld_q is high, so they
    // simply hold between qualified pairs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_vld_q <= 1'b0;
            p_q     <= '0;
            flags_q <= '0;
        end else begin
            p_vld_q <= go_i;
            if (go_i) begin
                p_q                 <= prod_d;
                flags_q[FLAG_FIRST] <= first_i;
                flags_q[FLAG_LAST]  <= last_i;
            end
        end
    end

    assign p_vld_o = p_vld_q;
    assign p_o     = p_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/pe_mac.sv
// ---------------------------------------------------------------------------
// pe_mac
// Accumulating systolic processing element. Forwards both operand streams to
// the east/south neighbours with one cycle of latency, multiplies qualified
// operand pairs (pe_mul, stage 1), accumulates products over a window framed
// by acc_first/acc_last (stage 2) and presents the finished sum on a
// valid/ready result port.
//
// Build option
//   PE_SAT_EN  defined: accumulator clamps to its limits on overflow
//              undefined: accumulator wraps in ACCW bits
//   err_ovf is raised on overflow in both builds.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   in0_vld/in0_data             operand 0 stream in
//   in1_vld/in1_data             operand 1 stream in
//   pe_en                        enables multiply/accumulate
//   acc_first/acc_last           dot-product framing, sampled with a pair
//   out0_vld/out0_data           operand 0 forwarded (registered)
//   out1_vld/out1_data           operand 1 forwarded (registered)
//   res_vld/res_data/res_rdy     result handshake
//   pe_doing                     partial sum or product in flight
//   err_ovr                      sticky: result dropped while one was held
//   err_ovf                      sticky: accumulator add overflowed
//
// Accumulator FSM
//   state   | meaning
//   ST_IDLE | no partial sum; next product starts a window
//   ST_ACC  | partial sum held in acc_q, window open
// ---------------------------------------------------------------------------
module pe_mac
    import pe_pkg::*;
#(
    parameter int DW     = 8,
    parameter int ACCW   = 32,
    parameter int SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in0_vld,
    input  logic [DW-1:0]   in0_data,
    input  logic            in1_vld,
    input  logic [DW-1:0]   in1_data,
    input  logic            pe_en,
    input  logic            acc_first,
    input  logic            acc_last,
    output logic            out0_vld,
    output logic [DW-1:0]   out0_data,
    output logic            out1_vld,
    output logic [DW-1:0]   out1_data,
    output logic            res_vld,
    output logic [ACCW-1:0] res_data,
    input  logic            res_rdy,
    output logic            pe_doing,
    output logic            err_ovr,
    output logic            err_ovf
);

`ifdef PE_SAT_EN
    localparam logic [ACCW-1:0] SAT_MAX = ACCW'(sat_max(ACCW, SIGNED != 0));
    localparam logic [ACCW-1:0] SAT_MIN = ACCW'(sat_min(ACCW, SIGNED != 0));
`endif

    // ---------------- pass-through ----------------
    logic            out0_vld_q;
    logic [DW-1:0]   out0_data_q;
    logic            out1_vld_q;
    logic [DW-1:0]   out1_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0_vld_q  <= 1'b0;
            out0_data_q <= '0;
            out1_vld_q  <= 1'b0;
            out1_data_q <= '0;
        end else begin
            out0_vld_q <= in0_vld;
            out1_vld_q <= in1_vld;
            if (in0_vld) begin
                out0_data_q <= in0_data;
            end
            if (in1_vld) begin
                out1_data_q <= in1_data;
            end
        end
    end

    // ---------------- stage 1: multiplier ----------------
    logic              mul_go;
    logic              p1_vld;
    logic [2*DW-1:0]   p1;
    logic [FLAG_W-1:0] p1_flags;

    assign mul_go = in0_vld & in1_vld & pe_en;

    pe_mul #(
        .DW     (DW),
        .SIGNED (SIGNED)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_i    (mul_go),
        .a_i     (in0_data),
        .b_i     (in1_data),
        .first_i (acc_first),
        .last_i  (acc_last),
        .p_vld_o (p1_vld),
        .p_o     (p1),
        .flags_o (p1_flags)
    );

    // ---------------- stage 2: accumulator ----------------
    pe_state_e       state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            res_vld_q, res_vld_d;
    logic [ACCW-1:0] res_q, res_d;
    logic            ovr_q, ovr_d;
    logic            ovf_q, ovf_d;

    logic [ACCW-1:0] p1_ext;
    logic [ACCW:0]   sum;
    logic            add_ovf;
    logic [ACCW-1:0] add_res;
    logic            start;
    logic [ACCW-1:0] acc_nxt;
    logic            p1_last;

    always_comb begin
        p1_ext = '0;
        p1_ext[2*DW-1:0] = p1;
        for (int i = 2*DW; i < ACCW; i++) begin
            p1_ext[i] = (SIGNED != 0) & p1[2*DW-1];
        end

        sum = {1'b0, acc_q} + {1'b0, p1_ext};
        if (SIGNED != 0) begin
            add_ovf = (acc_q[ACCW-1] == p1_ext[ACCW-1]) &&
                      (sum[ACCW-1] != acc_q[ACCW-1]);
        end else begin
            add_ovf = sum[ACCW];
        end

        add_res = sum[ACCW-1:0];
`ifdef PE_SAT_EN
        // Signed overflow can only happen with both operands of the same
        // sign, so the accumulator sign tells which limit to clamp to.
        if (add_ovf) begin
            if ((SIGNED != 0) && acc_q[ACCW-1]) begin
                add_res = SAT_MIN;
            end else begin
                add_res = SAT_MAX;
            end
        end
`endif

        // A product arriving in IDLE opens a window even without first.
        start   = (state_q == ST_IDLE) | p1_flags[FLAG_FIRST];
        p1_last = p1_flags[FLAG_LAST];
        acc_nxt = start ? p1_ext : add_res;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        res_vld_d = res_vld_q;
        res_d     = res_q;
        ovr_d     = ovr_q;
        ovf_d     = ovf_q;

        if (p1_vld) begin
            acc_d   = acc_nxt;
            state_d = p1_last ? ST_IDLE : ST_ACC;
            if (!start && add_ovf) begin
                ovf_d = 1'b1;
            end
        end

        // A transfer in the same cycle frees the slot for the new result.
        if (p1_vld && p1_last) begin
            if (!res_vld_q || res_rdy) begin
                res_vld_d = 1'b1;
                res_d     = acc_nxt;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (res_vld_q && res_rdy) begin
            res_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            res_vld_q <= 1'b0;
            res_q     <= '0;
            ovr_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            res_vld_q <= res_vld_d;
            res_q     <= res_d;
            ovr_q     <= ovr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out0_vld  = out0_vld_q;
    assign out0_data = out0_data_q;
    assign out1_vld  = out1_vld_q;
    assign out1_data = out1_data_q;
    assign res_vld   = res_vld_q;
    assign res_data  = res_q;
    assign pe_doing  = (state_q == ST_ACC) | p1_vld;
    assign err_ovr   = ovr_q;
    assign err_ovf   = ovf_q;

endmodule
